addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_pkg.sv | 14 +
 rtl/addsub_unit_8bit.sv | 21 ++
 rtl/addsub_arbiter.sv | 104 ++++++++++
 tb/tb_addsub_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and types for the add/sub arbiter slice.
package addsub_pkg;

  localparam int DATA_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/addsub_unit_8bit.sv
// Combinational 8-bit adder/subtractor with signed overflow detection.
module addsub_unit_8bit
  import addsub_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              op,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  logic [DATA_W-1:0] b_eff;

  // Subtract as a + ~b + 1; comparing against the effective operand covers both overflow rules.
  always_comb begin
    b_eff    = (op == OP_SUB) ? ~b : b;
    result   = a + b_eff + {{(DATA_W-1){1'b0}}, op};
    overflow = (a[DATA_W-1] == b_eff[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub unit across N_REQ requesters,
// with a single registered result stage (EMPTY/FULL).
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_op,
  input  logic [DATA_W*N_REQ-1:0] req_a,
  input  logic [DATA_W*N_REQ-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_result,
  output logic                    rsp_overflow
);

  localparam int unsigned N_REQ_U = N_REQ;

  out_state_e        state_q, state_d;
  logic [ID_W-1:0]   last_grant_q;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand;
  int unsigned       idx;
  logic              any_valid;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] sel_a, sel_b, alu_result;
  logic              sel_op, alu_overflow;

  // Search starts one past the last grant and wraps; the first valid requester wins.
  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ_U; k++) begin
      idx = k + 1 + {{(32-ID_W){1'b0}}, last_grant_q};
      if (idx >= N_REQ_U) idx = idx - N_REQ_U;
      cand = idx[ID_W-1:0];
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // rst_n gates acceptance so no handshake can be offered while reset is held.
  always_comb begin
    can_accept = rst_n && ((state_q == ST_EMPTY) || rsp_ready);
    accept     = can_accept && any_valid;
    req_ready  = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_a  = req_a[grant_idx*DATA_W +: DATA_W];
    sel_b  = req_b[grant_idx*DATA_W +: DATA_W];
    sel_op = req_op[grant_idx];
  end

  addsub_unit_8bit u_addsub (
    .a        (sel_a),
    .b        (sel_b),
    .op       (sel_op),
    .result   (alu_result),
    .overflow (alu_overflow)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (rsp_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= ID_W'(N_REQ - 1);
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= grant_idx;
        rsp_id       <= grant_idx;
        rsp_result   <= alu_result;
        rsp_overflow <= alu_overflow;
      end
    end
  end

  assign rsp_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter (N_REQ=4).
module tb_addsub_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_result;
  logic        rsp_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  addsub_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic op, input logic [7:0] a, input logic [7:0] b);
    req_op[i]        = op;
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] id, input logic [7:0] res, input logic ovf);
    check({tag, ".valid"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, ".id"}, {30'b0, rsp_id}, {30'b0, id});
    check({tag, ".result"}, {24'b0, rsp_result}, {24'b0, res});
    check({tag, ".ovf"}, {31'b0, rsp_overflow}, {31'b0, ovf});
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    req_valid = 4'hF;
    tick();
    tick();
    check("rst.valid", {31'b0, rsp_valid}, 32'd0);
    check("rst.id", {30'b0, rsp_id}, 32'd0);
    check("rst.result", {24'b0, rsp_result}, 32'd0);
    check("rst.ovf", {31'b0, rsp_overflow}, 32'd0);
    check("rst.ready", {28'b0, req_ready}, 32'd0);
    req_valid = '0;
    rst_n = 1'b1;

    // Req0 add 0x7F+0x01 accepted at the first edge after release
    set_req(0, 1'b0, 8'h7F, 8'h01);
    req_valid = 4'b0001;
    #1 check("add0.ready", {28'b0, req_ready}, 32'h1);
    tick();
    check_rsp("add0", 2'd0, 8'h80, 1'b1);
    req_valid = '0;
    tick();
    check("add0.drain", {31'b0, rsp_valid}, 32'd0);

    // Req2 subtract pair back-to-back
    set_req(2, 1'b1, 8'h80, 8'h01);
    req_valid = 4'b0100;
    #1 check("sub2a.ready", {28'b0, req_ready}, 32'h4);
    tick();
    check_rsp("sub2a", 2'd2, 8'h7F, 1'b1);
    set_req(2, 1'b1, 8'h05, 8'h07);
    #1 check("sub2b.ready", {28'b0, req_ready}, 32'h4);
    tick();
    check_rsp("sub2b", 2'd2, 8'hFE, 1'b0);
    set_req(2, 1'b1, 8'h7F, 8'hFF);
    tick();
    check_rsp("sub2c", 2'd2, 8'h80, 1'b1);
    req_valid = '0;
    tick();

    // Stall: hold result of req3 while req1 waits
    set_req(3, 1'b0, 8'h01, 8'h01);
    req_valid = 4'b1000;
    tick();
    check_rsp("fill3", 2'd3, 8'h02, 1'b0);
    rsp_ready = 1'b0;
    set_req(1, 1'b0, 8'h10, 8'h20);
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1 check("stall.ready", {28'b0, req_ready}, 32'h0);
      tick();
      check_rsp("stall.hold", 2'd3, 8'h02, 1'b0);
    end
    rsp_ready = 1'b1;
    #1 check("stall.release", {28'b0, req_ready}, 32'h2);
    tick();
    check_rsp("add1", 2'd1, 8'h30, 1'b0);
    req_valid = '0;
    tick();

    // All requesters valid from reset: round-robin 0,1,2,3,...
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(8'h10 * (i + 1)), 8'h01);
    req_valid = 4'hF;
    #1 check("rr.rst_ready", {28'b0, req_ready}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 check("rr.ready", {28'b0, req_ready}, 32'(1 << (k % 4)));
      tick();
      check_rsp("rr", 2'(k % 4), 8'(8'h10 * ((k % 4) + 1) + 1), 1'b0);
    end

    // Reset while FULL discards the held result
    rst_n = 1'b0;
    #1;
    check("midrst.valid", {31'b0, rsp_valid}, 32'd0);
    check("midrst.ready", {28'b0, req_ready}, 32'h0);
    check("midrst.result", {24'b0, rsp_result}, 32'd0);
    #2 rst_n = 1'b1;
    #1 check("midrst.ready0", {28'b0, req_ready}, 32'h1);
    tick();
    check_rsp("midrst.first", 2'd0, 8'h11, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
